// File: rtl/riscv_exec_mem_unit_pkg.sv
// Shared encodings for the RV32I decode/execute/memory stage: opcodes,
// ALU operation codes, next-PC select values and the funct3 -> ALU op mapping.
package riscv_exec_mem_unit_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_SRC_PLUS4 = 2'b00,
    PC_SRC_REL   = 2'b01,
    PC_SRC_JALR  = 2'b10
  } pc_src_e;

  // alt selects SUB/SRA; callers decide when funct7[5] is allowed to matter
  function automatic alu_op_e funct3_to_alu(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/riscv_exec_mem_unit_alu.sv
// Combinational RV32I ALU; shift amount comes from op_b[4:0].
module riscv_alu
  import riscv_exec_mem_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic [4:0] shamt;
  assign shamt = op_b[4:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:   result = op_a + op_b;
      ALU_SUB:   result = op_a - op_b;
      ALU_AND:   result = op_a & op_b;
      ALU_OR:    result = op_a | op_b;
      ALU_XOR:   result = op_a ^ op_b;
      ALU_SLL:   result = op_a << shamt;
      ALU_SRL:   result = op_a >> shamt;
      ALU_SRA:   result = $signed(op_a) >>> shamt;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_PASSB: result = op_b;
      default:   result = op_a + op_b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/riscv_exec_mem_unit_dmem.sv
// Word-addressed data memory: asynchronous read, clocked write, cleared by reset.
module riscv_dmem #(
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0]   mem_reg [DMEM_WORDS];
  logic [AW-1:0] index;
  logic          unused_addr_bits;

  // byte offset and bits above the array depth are dropped, so addresses wrap
  assign index            = addr[AW+1:2];
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (mem_write) begin
      mem_reg[index] <= wdata;
    end
  end

  assign rdata = (mem_read && rst_n) ? mem_reg[index] : 32'd0;

endmodule

// File: rtl/riscv_exec_mem_unit.sv
// Single-cycle RV32I decode + execute + data memory stage; the data memory
// is the only state, everything else is combinational from the inputs.
module riscv_exec_mem_unit
  import riscv_exec_mem_unit_pkg::*;
#(
  parameter int DMEM_WORDS = 256,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic            reg_write,
  output logic [1:0]      pc_src,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic [XLEN-1:0] wb_data
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign funct7_b5         = instr[30];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  logic            mem_read;
  logic            mem_write;
  logic            use_imm;
  logic            op_a_pc;
  logic            jump;
  logic            jalr;
  logic            branch;
  alu_op_e         alu_op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [31:0]     mem_rdata;
  logic            taken;

  always_comb begin
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    use_imm   = 1'b0;
    op_a_pc   = 1'b0;
    jump      = 1'b0;
    jalr      = 1'b0;
    branch    = 1'b0;
    alu_op    = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        reg_write = 1'b1;
        alu_op    = funct3_to_alu(funct3, funct7_b5);
      end
      OPC_OP_IMM: begin
        reg_write = 1'b1;
        use_imm   = 1'b1;
        // bit 30 of an I-type immediate only means "arithmetic" for SRAI
        alu_op    = funct3_to_alu(funct3, funct7_b5 && (funct3 == 3'b101));
      end
      OPC_LOAD: begin
        reg_write = 1'b1;
        mem_read  = 1'b1;
        use_imm   = 1'b1;
      end
      OPC_STORE: begin
        mem_write = 1'b1;
        use_imm   = 1'b1;
      end
      OPC_BRANCH: begin
        branch = 1'b1;
        case (funct3[2:1])
          2'b00:   alu_op = ALU_SUB;
          2'b10:   alu_op = ALU_SLT;
          2'b11:   alu_op = ALU_SLTU;
          default: alu_op = ALU_ADD;
        endcase
      end
      OPC_JAL: begin
        reg_write = 1'b1;
        jump      = 1'b1;
        op_a_pc   = 1'b1;
        use_imm   = 1'b1;
      end
      OPC_JALR: begin
        reg_write = 1'b1;
        jump      = 1'b1;
        jalr      = 1'b1;
        use_imm   = 1'b1;
      end
      OPC_LUI: begin
        reg_write = 1'b1;
        use_imm   = 1'b1;
        alu_op    = ALU_PASSB;
      end
      OPC_AUIPC: begin
        reg_write = 1'b1;
        op_a_pc   = 1'b1;
        use_imm   = 1'b1;
      end
      default: ;
    endcase
  end

  assign op_a = op_a_pc ? pc : rs1_data;
  assign op_b = use_imm ? imm : rs2_data;

  riscv_alu #(.XLEN(XLEN)) u_alu (
    .op_a   (op_a),
    .op_b   (op_b),
    .op     (alu_op),
    .result (alu_result),
    .zero   (zero)
  );

  riscv_dmem #(.DMEM_WORDS(DMEM_WORDS)) u_dmem (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (alu_result),
    .wdata     (rs2_data),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .rdata     (mem_rdata)
  );

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:         taken = zero;
      3'b001:         taken = !zero;
      3'b100, 3'b110: taken = alu_result[0];
      3'b101, 3'b111: taken = !alu_result[0];
      default:        taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_src = PC_SRC_PLUS4;
    if (jalr)
      pc_src = PC_SRC_JALR;
    else if (jump || (branch && taken))
      pc_src = PC_SRC_REL;
  end

  always_comb begin
    if (mem_read)
      wb_data = mem_rdata;
    else if (jump)
      wb_data = pc + 32'd4;
    else
      wb_data = alu_result;
  end

endmodule

// File: tb/tb_riscv_exec_mem_unit.sv
// Directed-vector bench for riscv_exec_mem_unit with hand-computed expectations.
module tb_riscv_exec_mem_unit;

  localparam int DMEM_WORDS = 256;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic        reg_write;
  logic [1:0]  pc_src;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] wb_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  riscv_exec_mem_unit #(.DMEM_WORDS(DMEM_WORDS), .XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .pc         (pc),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .imm        (imm),
    .reg_write  (reg_write),
    .pc_src     (pc_src),
    .alu_result (alu_result),
    .zero       (zero),
    .wb_data    (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one instruction just after a falling edge and let outputs settle.
  task automatic apply(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im);
    @(negedge clk);
    instr = i; pc = p; rs1_data = a; rs2_data = b; imm = im;
    #1;
    $display("txn instr=%08h pc=%08h rs1=%08h rs2=%08h imm=%08h -> rw=%0b pc_src=%02b alu=%08h wb=%08h",
             i, p, a, b, im, reg_write, pc_src, alu_result, wb_data);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    apply(32'h0040A183, 32'h0, 32'h10, 32'h0, 32'h4);  // LW during reset
    total_cnt++; if (wb_data !== 32'h0) $display("FAIL reset_load: got %08h expected %08h", wb_data, 32'h0); else pass_cnt++;
    total_cnt++; if (reg_write !== 1'b1) $display("FAIL reset_load_rw: got %0b expected 1", reg_write); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu;
    apply(32'h002081B3, 32'h0, 32'd5, 32'd7, 32'h0);  // ADD
    total_cnt++; if (alu_result !== 32'd12) $display("FAIL add_alu: got %08h expected %08h", alu_result, 32'd12); else pass_cnt++;
    total_cnt++; if (reg_write !== 1'b1) $display("FAIL add_rw: got %0b expected 1", reg_write); else pass_cnt++;
    total_cnt++; if (wb_data !== 32'd12) $display("FAIL add_wb: got %08h expected %08h", wb_data, 32'd12); else pass_cnt++;
    total_cnt++; if (pc_src !== 2'b00) $display("FAIL add_pc_src: got %02b expected 00", pc_src); else pass_cnt++;
    apply(32'h402081B3, 32'h0, 32'h80000000, 32'd4, 32'h0);  // SUB
    total_cnt++; if (wb_data !== 32'h7FFFFFFC) $display("FAIL sub: got %08h expected %08h", wb_data, 32'h7FFFFFFC); else pass_cnt++;
    apply(32'h4020D1B3, 32'h0, 32'h80000000, 32'd4, 32'h0);  // SRA
    total_cnt++; if (wb_data !== 32'hF8000000) $display("FAIL sra: got %08h expected %08h", wb_data, 32'hF8000000); else pass_cnt++;
    apply(32'h0020D1B3, 32'h0, 32'h80000000, 32'd4, 32'h0);  // SRL
    total_cnt++; if (wb_data !== 32'h08000000) $display("FAIL srl: got %08h expected %08h", wb_data, 32'h08000000); else pass_cnt++;
    apply(32'h0020B1B3, 32'h0, 32'd1, 32'hFFFFFFFF, 32'h0);  // SLTU
    total_cnt++; if (wb_data !== 32'd1) $display("FAIL sltu: got %08h expected %08h", wb_data, 32'd1); else pass_cnt++;
    apply(32'h0020A1B3, 32'h0, 32'd1, 32'hFFFFFFFF, 32'h0);  // SLT: 1 < -1 is false
    total_cnt++; if (wb_data !== 32'd0) $display("FAIL slt: got %08h expected %08h", wb_data, 32'd0); else pass_cnt++;
    total_cnt++; if (zero !== 1'b1) $display("FAIL slt_zero: got %0b expected 1", zero); else pass_cnt++;
  endtask

  task automatic test_op_imm;
    apply(32'h40008093, 32'h0, 32'd5, 32'h0, 32'h400);  // ADDI with bit 30 set stays ADD
    total_cnt++; if (wb_data !== 32'h405) $display("FAIL addi_bit30: got %08h expected %08h", wb_data, 32'h405); else pass_cnt++;
    apply(32'h4040D093, 32'h0, 32'h80000000, 32'h0, 32'h404);  // SRAI by 4
    total_cnt++; if (wb_data !== 32'hF8000000) $display("FAIL srai: got %08h expected %08h", wb_data, 32'hF8000000); else pass_cnt++;
  endtask

  task automatic test_branch;
    apply(32'h00208063, 32'h0, 32'd9, 32'd9, 32'h10);  // BEQ
    total_cnt++; if (pc_src !== 2'b01) $display("FAIL beq: got %02b expected 01", pc_src); else pass_cnt++;
    total_cnt++; if (reg_write !== 1'b0) $display("FAIL beq_rw: got %0b expected 0", reg_write); else pass_cnt++;
    apply(32'h00209063, 32'h0, 32'd9, 32'd9, 32'h10);  // BNE
    total_cnt++; if (pc_src !== 2'b00) $display("FAIL bne: got %02b expected 00", pc_src); else pass_cnt++;
    apply(32'h0020C063, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h10);  // BLT
    total_cnt++; if (pc_src !== 2'b01) $display("FAIL blt: got %02b expected 01", pc_src); else pass_cnt++;
    apply(32'h0020D063, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h10);  // BGE, -1 >= 1 false
    total_cnt++; if (pc_src !== 2'b00) $display("FAIL bge: got %02b expected 00", pc_src); else pass_cnt++;
    apply(32'h0020F063, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h10);  // BGEU
    total_cnt++; if (pc_src !== 2'b01) $display("FAIL bgeu: got %02b expected 01", pc_src); else pass_cnt++;
    apply(32'h0020E063, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h10);  // BLTU
    total_cnt++; if (pc_src !== 2'b00) $display("FAIL bltu: got %02b expected 00", pc_src); else pass_cnt++;
  endtask

  task automatic test_jump_upper;
    apply(32'h000000EF, 32'h100, 32'h0, 32'h0, 32'h20);  // JAL
    total_cnt++; if (pc_src !== 2'b01) $display("FAIL jal_pc_src: got %02b expected 01", pc_src); else pass_cnt++;
    total_cnt++; if (wb_data !== 32'h104) $display("FAIL jal_wb: got %08h expected %08h", wb_data, 32'h104); else pass_cnt++;
    apply(32'h000080E7, 32'h100, 32'h201, 32'h0, 32'h0);  // JALR
    total_cnt++; if (pc_src !== 2'b10) $display("FAIL jalr_pc_src: got %02b expected 10", pc_src); else pass_cnt++;
    total_cnt++; if (wb_data !== 32'h104) $display("FAIL jalr_wb: got %08h expected %08h", wb_data, 32'h104); else pass_cnt++;
    apply(32'h123450B7, 32'h100, 32'h55, 32'h0, 32'h12345000);  // LUI
    total_cnt++; if (wb_data !== 32'h12345000) $display("FAIL lui: got %08h expected %08h", wb_data, 32'h12345000); else pass_cnt++;
    apply(32'h00001097, 32'h100, 32'h55, 32'h0, 32'h1000);  // AUIPC
    total_cnt++; if (wb_data !== 32'h1100) $display("FAIL auipc: got %08h expected %08h", wb_data, 32'h1100); else pass_cnt++;
  endtask

  task automatic test_store_load;
    apply(32'h0020A223, 32'h0, 32'h10, 32'hDEADBEEF, 32'h4);  // SW
    total_cnt++; if (reg_write !== 1'b0) $display("FAIL sw_rw: got %0b expected 0", reg_write); else pass_cnt++;
    total_cnt++; if (alu_result !== 32'h14) $display("FAIL sw_addr: got %08h expected %08h", alu_result, 32'h14); else pass_cnt++;
    apply(32'h0040A183, 32'h0, 32'h10, 32'h0, 32'h4);  // LW same word
    total_cnt++; if (wb_data !== 32'hDEADBEEF) $display("FAIL lw: got %08h expected %08h", wb_data, 32'hDEADBEEF); else pass_cnt++;
    apply(32'h0000A183, 32'h0, 32'h14 + 4 * DMEM_WORDS, 32'h0, 32'h0);  // aliased address
    total_cnt++; if (wb_data !== 32'hDEADBEEF) $display("FAIL lw_alias: got %08h expected %08h", wb_data, 32'hDEADBEEF); else pass_cnt++;
    apply(32'h0000A183, 32'h0, 32'h17, 32'h0, 32'h0);  // byte offset ignored
    total_cnt++; if (wb_data !== 32'hDEADBEEF) $display("FAIL lw_offset: got %08h expected %08h", wb_data, 32'hDEADBEEF); else pass_cnt++;
    apply(32'h0000A183, 32'h0, 32'h18, 32'h0, 32'h0);  // neighbouring word untouched
    total_cnt++; if (wb_data !== 32'h0) $display("FAIL lw_neighbour: got %08h expected %08h", wb_data, 32'h0); else pass_cnt++;
  endtask

  task automatic test_illegal;
    apply(32'h0020A27F, 32'h0, 32'h10, 32'h11111111, 32'h4);  // opcode 0x7F
    total_cnt++; if (reg_write !== 1'b0) $display("FAIL illegal_rw: got %0b expected 0", reg_write); else pass_cnt++;
    total_cnt++; if (pc_src !== 2'b00) $display("FAIL illegal_pc_src: got %02b expected 00", pc_src); else pass_cnt++;
    apply(32'h0040A183, 32'h0, 32'h10, 32'h0, 32'h4);
    total_cnt++; if (wb_data !== 32'hDEADBEEF) $display("FAIL illegal_mem: got %08h expected %08h", wb_data, 32'hDEADBEEF); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    apply(32'h0020A223, 32'h0, 32'h20, 32'hCAFEF00D, 32'h0);
    apply(32'h0020A223, 32'h0, 32'h24, 32'h0BADF00D, 32'h0);
    apply(32'h0000A183, 32'h0, 32'h20, 32'h0, 32'h0);
    total_cnt++; if (wb_data !== 32'hCAFEF00D) $display("FAIL b2b_word0: got %08h expected %08h", wb_data, 32'hCAFEF00D); else pass_cnt++;
    apply(32'h0000A183, 32'h0, 32'h24, 32'h0, 32'h0);
    total_cnt++; if (wb_data !== 32'h0BADF00D) $display("FAIL b2b_word1: got %08h expected %08h", wb_data, 32'h0BADF00D); else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    apply(32'h0000A183, 32'h0, 32'h20, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (wb_data !== 32'h0) $display("FAIL reset_immediate: got %08h expected %08h", wb_data, 32'h0); else pass_cnt++;
    apply(32'h0020A223, 32'h0, 32'h20, 32'h55555555, 32'h0);  // store across a clock edge held in reset
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply(32'h0000A183, 32'h0, 32'h20, 32'h0, 32'h0);
    total_cnt++; if (wb_data !== 32'h0) $display("FAIL reset_blocks_store: got %08h expected %08h", wb_data, 32'h0); else pass_cnt++;
    apply(32'h0040A183, 32'h0, 32'h10, 32'h0, 32'h4);
    total_cnt++; if (wb_data !== 32'h0) $display("FAIL reset_clears: got %08h expected %08h", wb_data, 32'h0); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; pc = '0; rs1_data = '0; rs2_data = '0; imm = '0;
    test_reset();
    test_alu();
    test_op_imm();
    test_branch();
    test_jump_upper();
    test_store_load();
    test_illegal();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/riscv_exec_mem_unit.md
Name: riscv_exec_mem_unit

Overview:
Combinational decode, execute and data-memory stage of the single-cycle RV32I core. Takes the fetched instruction, PC, register-file operands and the generated immediate. Produces register write-enable, next-PC select, ALU result/flags and write-back data. Sits between the register file/immediate generator and the PC/register write-back path; the only state is the data memory.

Parameters:
DMEM_WORDS, 256, data memory depth in 32-bit words (power of two)
XLEN, 32, datapath width (fixed at 32)

Ports:
clk  in  1  rising-edge clock for data-memory writes
rst_n  in  1  asynchronous active-low reset; clears data memory
instr  in  32  current instruction
pc  in  32  current PC
rs1_data  in  32  register read port 1
rs2_data  in  32  register read port 2 (also store data)
imm  in  32  sign-extended immediate for instr's format
reg_write  out  1  register-file write enable
pc_src  out  2  00 = pc+4, 01 = pc+imm, 10 = (rs1+imm)&~1, 11 unused
alu_result  out  32  ALU result / memory address
zero  out  1  alu_result == 0
wb_data  out  32  register write-back value

Behaviour:
- All outputs combinational from inputs and memory contents; no pipeline latency.
- Opcode decode (instr[6:0]) gives reg_write / mem_read / mem_write / alu_src / ALU op-a source:
  - R 0110011: 1/0/0/rs2/rs1
  - OP-IMM 0010011: 1/0/0/imm/rs1
  - LOAD 0000011: 1/1/0/imm/rs1
  - STORE 0100011: 0/0/1/imm/rs1
  - BRANCH 1100011: 0/0/0/rs2/rs1
  - JAL 1101111: reg_write=1, jump=1
  - JALR 1100111: reg_write=1, jump=1
  - LUI 0110111: reg_write=1, result = imm
  - AUIPC 0010111: reg_write=1, result = pc+imm
- Any other opcode: all enables 0, pc_src=00, ALU op ADD.
- ALU ops (4-bit, shared package): ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, PASSB 1010.
- R-type funct3 mapping: 000 ADD, or SUB when funct7[5]=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7[5]=1; 110 OR; 111 AND.
- OP-IMM uses the same funct3 mapping. funct7[5] is honoured only for funct3=101 (SRAI); ADDI is never SUB.
- Shift amount is op-b[4:0]. SLT/SLTU return 0 or 1 in bit 0.
- LOAD/STORE/JAL/JALR use ADD.
- Branch compare selection: BEQ/BNE use SUB; BLT/BGE use SLT; BLTU/BGEU use SLTU.
- Branch taken conditions:
  - BEQ: zero
  - BNE: !zero
  - BLT, BLTU: result[0]
  - BGE, BGEU: !result[0]
  - funct3 010/011: never taken
- pc_src: taken branch or JAL gives 01; JALR gives 10; otherwise 00.
- wb_data: mem_read selects DMEM read data; else jump selects pc+4; else alu_result.
- Data memory:
  - Word-only (LW/SW regardless of funct3).
  - Index = alu_result[log2(DMEM_WORDS)+1:2]; byte offset ignored; higher address bits ignored, so addresses wrap.
  - Read is asynchronous.
  - Write occurs at posedge clk when mem_write=1, storing rs2_data.
  - Read data when mem_read=0 is don't-care, but is driven as 0.
  - Same-cycle store then load to the same word: the load sees the new value the following cycle.
- Reset: while rst_n=0 every memory word reads 0 immediately and writes are blocked. Reset asserted mid-cycle discards any pending store.

Decomposition:
- Shared package: opcode constants, ALU op codes, pc_src encodings.
- Natural sub-modules: riscv_alu (op-a, op-b, op → result, zero) and riscv_dmem. Decode stays in the top of this block.

Test Plan:
- ADD x3 = 5 + 7 (instr 0x002081B3, rs1=5, rs2=7) → alu_result=12, reg_write=1, wb_data=12, pc_src=00.
- SUB/SRA/SLTU: rs1=0x80000000, rs2=4 → SUB gives 0x7FFFFFFC; SRA gives 0xF8000000; SLTU rs1=1, rs2=0xFFFFFFFF gives 1.
- SW rs2=0xDEADBEEF at rs1=0x10, imm=4, then next cycle LW from same address → wb_data=0xDEADBEEF, reg_write=0 on SW; address 0x14+4*DMEM_WORDS aliases the same word.
- BEQ with rs1=rs2=9 → pc_src=01. BNE with the same operands → 00. BLT with -1 < 1 → 01. BGEU with 0xFFFFFFFF ≥ 1 → 01.
- JAL → pc_src=01, wb_data=pc+4. JALR → pc_src=10, wb_data=pc+4. LUI imm=0x12345000 → wb_data=0x12345000. AUIPC pc=0x100, imm=0x1000 → 0x1100.
- Store a word, pulse rst_n low between clock edges → load returns 0. Opcode 0x7F → reg_write=0, pc_src=00, memory unchanged.
